// File: rtl/el2_ifu_dec_ibuf.sv
// Instruction buffer between the IFU aligner and decode: a small FIFO of
// aligned instructions with PC, size and fault attributes; head feeds decode.
module el2_ifu_dec_ibuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        aln_valid,
  output logic        aln_ready,
  input  logic [31:0] aln_instr,
  input  logic [15:0] aln_cinst,
  input  logic [30:0] aln_pc,
  input  logic        aln_pc4,
  input  logic        aln_icaf,
  input  logic [1:0]  aln_icaf_type,
  input  logic        aln_icaf_second,
  input  logic        aln_dbecc,
  input  logic        flush,
  input  logic        dec_i0_decode_d,
  output logic        ifu_i0_valid,
  output logic [31:0] ifu_i0_instr,
  output logic [15:0] ifu_i0_cinst,
  output logic [30:0] ifu_i0_pc,
  output logic        ifu_i0_pc4,
  output logic        ifu_i0_icaf,
  output logic [1:0]  ifu_i0_icaf_type,
  output logic        ifu_i0_icaf_second,
  output logic        ifu_i0_dbecc,
  output logic        ibuf_pmu_full_stall,
  output logic        ibuf_pop_empty_err
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] cinst;
    logic [30:0] pc;
    logic        pc4;
    logic        icaf;
    logic [1:0]  icaf_type;
    logic        icaf_second;
    logic        dbecc;
  } entry_t;

  entry_t             entry_mem [DEPTH];
  entry_t             wr_data;
  entry_t             head;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;

  assign aln_ready           = (count != (PTR_W+1)'(DEPTH));
  assign ifu_i0_valid        = (count != '0);
  assign ibuf_pmu_full_stall = aln_valid & ~aln_ready;

  // Flush masks both sides so nothing moves in the flush cycle.
  assign push = aln_valid & aln_ready & ~flush;
  assign pop  = dec_i0_decode_d & ifu_i0_valid & ~flush;

  assign wr_data = '{instr:       aln_instr,
                     cinst:       aln_cinst,
                     pc:          aln_pc,
                     pc4:         aln_pc4,
                     icaf:        aln_icaf,
                     icaf_type:   aln_icaf_type,
                     icaf_second: aln_icaf_second,
                     dbecc:       aln_dbecc};

  // Payload storage is intentionally unreset; valid is derived from count only.
  always_ff @(posedge clk) begin
    if (push) entry_mem[wr_ptr] <= wr_data;
  end

  assign head               = entry_mem[rd_ptr];
  assign ifu_i0_instr       = head.instr;
  assign ifu_i0_cinst       = head.cinst;
  assign ifu_i0_pc          = head.pc;
  assign ifu_i0_pc4         = head.pc4;
  assign ifu_i0_icaf        = head.icaf;
  assign ifu_i0_icaf_type   = head.icaf_type;
  assign ifu_i0_icaf_second = head.icaf_second;
  assign ifu_i0_dbecc       = head.dbecc;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky diagnostic: decode retired an instruction the buffer never held.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ibuf_pop_empty_err <= 1'b0;
    end else if (dec_i0_decode_d & ~ifu_i0_valid & ~flush) begin
      ibuf_pop_empty_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_el2_ifu_dec_ibuf.sv
// Directed bench for el2_ifu_dec_ibuf: a queue scoreboard models the FIFO and
// every cycle compares head payload, handshakes, flags and pointers.
module tb_el2_ifu_dec_ibuf;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] cinst;
    logic [30:0] pc;
    logic        pc4;
    logic        icaf;
    logic [1:0]  icaf_type;
    logic        icaf_second;
    logic        dbecc;
  } ent_t;

  logic        clk = 0;
  logic        rst_l;
  logic        aln_valid;
  logic        aln_ready;
  logic [31:0] aln_instr;
  logic [15:0] aln_cinst;
  logic [30:0] aln_pc;
  logic        aln_pc4;
  logic        aln_icaf;
  logic [1:0]  aln_icaf_type;
  logic        aln_icaf_second;
  logic        aln_dbecc;
  logic        flush;
  logic        dec_i0_decode_d;
  logic        ifu_i0_valid;
  logic [31:0] ifu_i0_instr;
  logic [15:0] ifu_i0_cinst;
  logic [30:0] ifu_i0_pc;
  logic        ifu_i0_pc4;
  logic        ifu_i0_icaf;
  logic [1:0]  ifu_i0_icaf_type;
  logic        ifu_i0_icaf_second;
  logic        ifu_i0_dbecc;
  logic        ibuf_pmu_full_stall;
  logic        ibuf_pop_empty_err;

  el2_ifu_dec_ibuf #(.DEPTH(4)) dut (
    .clk(clk), .rst_l(rst_l),
    .aln_valid(aln_valid), .aln_ready(aln_ready),
    .aln_instr(aln_instr), .aln_cinst(aln_cinst), .aln_pc(aln_pc),
    .aln_pc4(aln_pc4), .aln_icaf(aln_icaf), .aln_icaf_type(aln_icaf_type),
    .aln_icaf_second(aln_icaf_second), .aln_dbecc(aln_dbecc),
    .flush(flush), .dec_i0_decode_d(dec_i0_decode_d),
    .ifu_i0_valid(ifu_i0_valid), .ifu_i0_instr(ifu_i0_instr),
    .ifu_i0_cinst(ifu_i0_cinst), .ifu_i0_pc(ifu_i0_pc),
    .ifu_i0_pc4(ifu_i0_pc4), .ifu_i0_icaf(ifu_i0_icaf),
    .ifu_i0_icaf_type(ifu_i0_icaf_type),
    .ifu_i0_icaf_second(ifu_i0_icaf_second), .ifu_i0_dbecc(ifu_i0_dbecc),
    .ibuf_pmu_full_stall(ibuf_pmu_full_stall),
    .ibuf_pop_empty_err(ibuf_pop_empty_err)
  );

  always #5 clk = ~clk;

  localparam int DEPTH = 4;

  ent_t     sb[$];
  logic     err_m;
  int       rd_m, wr_m;
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] instr, input logic [15:0] cinst,
                              input logic [30:0] pc, input logic pc4, input logic [5:0] flt);
    ent_t e;
    e.instr = instr; e.cinst = cinst; e.pc = pc; e.pc4 = pc4;
    e.icaf = flt[0]; e.icaf_type = flt[2:1]; e.icaf_second = flt[3]; e.dbecc = flt[4];
    return e;
  endfunction

  function automatic ent_t head_obs();
    ent_t e;
    e.instr = ifu_i0_instr; e.cinst = ifu_i0_cinst; e.pc = ifu_i0_pc; e.pc4 = ifu_i0_pc4;
    e.icaf = ifu_i0_icaf; e.icaf_type = ifu_i0_icaf_type;
    e.icaf_second = ifu_i0_icaf_second; e.dbecc = ifu_i0_dbecc;
    return e;
  endfunction

  task automatic check_state();
    bit exp_valid, exp_ready;
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() != DEPTH);
    chk("valid", 128'(ifu_i0_valid), 128'(exp_valid));
    chk("aln_ready", 128'(aln_ready), 128'(exp_ready));
    chk("full_stall", 128'(ibuf_pmu_full_stall), 128'(aln_valid & ~exp_ready));
    chk("pop_empty_err", 128'(ibuf_pop_empty_err), 128'(err_m));
    chk("count", 128'(dut.count), 128'(sb.size()));
    chk("rd_ptr", 128'(dut.rd_ptr), 128'(rd_m));
    chk("wr_ptr", 128'(dut.wr_ptr), 128'(wr_m));
    if (exp_valid) chk("head_payload", 128'(head_obs()), 128'(sb[0]));
  endtask

  // One clock: drive at negedge, check at negedge+1, update model at posedge.
  task automatic cycle(input bit v, input ent_t e, input bit dec, input bit fl);
    bit exp_valid, exp_ready, do_push, do_pop;
    @(negedge clk);
    aln_valid = v; dec_i0_decode_d = dec; flush = fl;
    {aln_instr, aln_cinst, aln_pc, aln_pc4, aln_icaf, aln_icaf_type,
     aln_icaf_second, aln_dbecc} = e;
    #1;
    check_state();
    exp_valid = (sb.size() != 0);
    exp_ready = (sb.size() != DEPTH);
    do_push = v & exp_ready & ~fl;
    do_pop  = dec & exp_valid & ~fl;
    $display("cyc %0d: v=%0b dec=%0b flush=%0b push=%0b pop=%0b instr=%08h pc=%08h occ=%0d",
             cyc, v, dec, fl, do_push, do_pop, e.instr, e.pc, sb.size());
    @(posedge clk);
    cyc++;
    if (fl) begin
      sb.delete(); rd_m = 0; wr_m = 0;
    end else begin
      if (do_pop)  begin void'(sb.pop_front()); rd_m = (rd_m + 1) % DEPTH; end
      if (do_push) begin sb.push_back(e); wr_m = (wr_m + 1) % DEPTH; end
      if (dec && !exp_valid) err_m = 1'b1;
    end
  endtask

  task automatic model_reset();
    sb.delete(); rd_m = 0; wr_m = 0; err_m = 1'b0;
  endtask

  ent_t nul;
  ent_t e;

  initial begin
    nul = '0;
    rst_l = 1'b0; aln_valid = 0; dec_i0_decode_d = 0; flush = 0;
    {aln_instr, aln_cinst, aln_pc, aln_pc4, aln_icaf, aln_icaf_type,
     aln_icaf_second, aln_dbecc} = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_state();
    @(negedge clk) rst_l = 1'b1;

    // Single push: invisible in push cycle, visible next cycle
    e = mk(32'h00A00093, 16'h0000, 31'(32'h8000_0000 >> 1), 1'b1, 6'h0);
    cycle(1, e, 0, 0);
    cycle(0, nul, 0, 0);
    cycle(0, nul, 1, 0);

    // Fill to DEPTH, then a refused fifth push
    for (int i = 0; i < 4; i++)
      cycle(1, mk(32'h1000_0000 + i, 16'(16'hC000 + i), 31'(32'h200 + 2 * i), i[0],
                  6'(i + 1)), 0, 0);
    cycle(1, mk(32'hDEAD_BEEF, 16'hBEEF, 31'h7FFF_FFFF, 1'b1, 6'h1F), 0, 0);

    // Full with simultaneous pop and push attempt: pop only
    cycle(1, mk(32'hCAFE_F00D, 16'hF00D, 31'h1234, 1'b0, 6'h0A), 1, 0);
    cycle(0, nul, 0, 0);

    // Flush with 3 held, along with push and pop
    cycle(1, mk(32'h5555_AAAA, 16'h5A5A, 31'h4444, 1'b1, 6'h15), 1, 1);
    cycle(0, nul, 0, 0);
    cycle(1, mk(32'h0001_0113, 16'h0415, 31'(32'h100 >> 1), 1'b1, 6'h16), 0, 0);

    // Streaming push+pop: occupancy stays 1, pointers wrap
    for (int i = 0; i < 10; i++)
      cycle(1, mk(32'h0000_4000 + 32'(i), 16'(16'h4000 + 16'(i) * 3),
                  31'(32'h100 + 2 * i), 1'b0, 6'(i)), 1, 0);
    cycle(0, nul, 1, 0);

    // Pop while empty sets the sticky flag; flushes do not clear it
    cycle(0, nul, 1, 0);
    cycle(0, nul, 0, 1);
    cycle(1, mk(32'h0BAD_0BAD, 16'h0B0B, 31'h55, 1'b1, 6'h03), 0, 1);
    cycle(0, nul, 0, 0);

    // Random traffic
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)),
            mk($urandom, 16'($urandom), 31'($urandom), 1'($urandom), 6'($urandom)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));

    // Async reset mid-operation discards entries immediately
    cycle(1, mk(32'h7777_7777, 16'h7777, 31'h777, 1'b1, 6'h07), 0, 0);
    cycle(1, mk(32'h8888_8888, 16'h8888, 31'h888, 1'b0, 6'h08), 1, 0);
    @(negedge clk);
    aln_valid = 0; dec_i0_decode_d = 0; flush = 0;
    #2 rst_l = 1'b0;
    model_reset();
    #1 check_state();
    @(negedge clk) rst_l = 1'b1;

    // Flag is clear after reset and stays clear
    cycle(0, nul, 0, 0);
    cycle(0, nul, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
